irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Programmable interrupt controller between the memory-mapped peripherals (timers, I/O devices) and CP0's six-bit `HWInt` input. It latches device requests as edge- or level-triggered pending bits, masks them per source, and drives `hw_int` to CP0. A claim/end-of-interrupt handshake over the bridge lets the exception handler identify and retire the highest-priority source. It sits on the bridge at base 0x0000_7F20, alongside the timers.

## Interface
- `NSRC`, 6: number of interrupt sources; must equal CP0 `HWInt` width.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `dev_irq`  in  NSRC  raw device requests; synchronous to `clk`.
- `addr`  in  2  word offset from bridge (byte address bits [3:2]).
- `we`  in  1  register write strobe, one cycle per access.
- `re`  in  1  register read strobe; needed for the side effect of a CLAIM read.
- `wdata`  in  32  write data from the GPR.
- `rdata`  out  32  combinational read data for `addr`.
- `hw_int`  out  NSRC  registered interrupt lines to CP0 `HWInt`.

## Operation
- Registers: 0 MODE[5:0] (1=edge, 0=level); 1 ENABLE[5:0]; 2 PENDING[5:0] (read; write-1-to-clear for edge sources); 3 CLAIM (read = claim, write = EOI). Upper bits read 0 and are ignored on write.
- Edge detect: `prev <= dev_irq`. Edge source i sets pending[i] when `dev_irq[i] & ~prev[i]`. Level source i uses pending[i] = `dev_irq[i]` registered each cycle; W1C and claim do not clear it.
- In-service vector `insvc[5:0]`: a CLAIM read with `re` sets insvc[id]. An edge source's pending bit is also cleared by the claim.
- Claim id = lowest index i with pending[i] & ENABLE[i] & ~insvc[i]. CLAIM reads return {26'b0, valid, 2'b0, i} with valid in bit 5. It returns 0 when nothing is eligible, and then has no side effect.
- EOI: a CLAIM write clears insvc[wdata[2:0]]. Ids ≥ NSRC are ignored.
- `hw_int <= pending & ENABLE & ~insvc`.
- Simultaneous events: a new edge in the same cycle as a W1C or claim of the same bit leaves pending=1 (set wins). A MODE change from edge to level clears that pending bit. A claim and an EOI cannot coincide, because only one access occurs per cycle.

## Timing
- Reset (async, `reset`=0): MODE, ENABLE, PENDING, insvc, prev and `hw_int` all become 0. `rdata` then reads 0 for every address.
- Latency from `dev_irq` rise at edge N to `hw_int` high after edge N+2: pending is set at N+1 and `hw_int` is registered at N+2.
- Register writes take effect at the next edge. Their effect on `hw_int` appears one edge later.
- `rdata` is combinational from the current state. Claim side effects commit at the edge ending the `re` cycle.
- If reset is asserted mid-handshake, all in-service state is lost. The handler must tolerate a spurious EOI afterwards; it is harmless.

## Structure
- Shared package `irq_pkg`: register offsets (MODE=0, ENABLE=1, PENDING=2, CLAIM=3), base address 0x7F20, and the CLAIM valid-bit position.
- Sub-module `irq_prio_enc`: a combinational lowest-index priority encoder, NSRC → {valid, id[2:0]}, reused by the bridge for debug reads.
- Expected implementation size is about 150–250 lines of RTL.

## Test plan
- Reset check: hold `reset`=0 with `dev_irq`=6'h3F. Required: `hw_int`=0 and every register reads 0. After release, `hw_int` must stay 0 until ENABLE is written.
- Edge latency: MODE=6'h01, ENABLE=6'h01, pulse `dev_irq[0]` for 1 cycle. Required: `hw_int[0]`=1 two edges later, and it stays 1 after the pulse ends.
- Claim and EOI, two sources: MODE=6'h03, ENABLE=6'h03, raise sources 0 and 1. First CLAIM read returns 0x20 and `hw_int` becomes 6'h02. Second read returns 0x21. Write CLAIM=0 then 1. Required: PENDING=0 and `hw_int`=0.
- Level source: MODE=0, ENABLE=6'h04, hold `dev_irq[2]`=1. CLAIM returns 0x22. After EOI, `hw_int[2]` reasserts. After dropping `dev_irq[2]`, `hw_int[2]`=0 two edges later.
- Set-wins race: edge source 3 pending, W1C PENDING=6'h08 in the same cycle as a new rising edge on `dev_irq[3]`. Required: pending[3] stays 1.
- Empty claim: no pending sources, CLAIM read returns 0. Required: insvc unchanged; a subsequent edge on source 5 still reaches `hw_int[5]`.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the bridge-attached interrupt controller:
// register map, bridge base address and CLAIM word layout.
package irq_pkg;

  typedef enum logic [1:0] {
    REG_MODE    = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_PENDING = 2'd2,
    REG_CLAIM   = 2'd3
  } reg_off_e;

  localparam logic [31:0] IRQ_BASE        = 32'h0000_7F20;
  localparam int unsigned CLAIM_VALID_BIT = 5;

  function automatic logic [31:0] claim_word(input logic valid, input logic [2:0] id);
    claim_word                  = '0;
    claim_word[CLAIM_VALID_BIT] = valid;
    claim_word[2:0]             = id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; id reads 0 when nothing is requesting.
import irq_pkg::*;

module irq_prio_enc #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    // Scan downward so the lowest requesting index is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        valid = 1'b1;
        id    = 3'(i - 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level pending capture, per-source enable,
// claim/EOI in-service tracking and registered hw_int lines to CP0.
import irq_pkg::*;

module irq_ctrl #(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] dev_irq,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hw_int
);

  reg_off_e        off;
  logic [NSRC-1:0] mode, enable, pending, insvc, prev;
  logic [NSRC-1:0] eligible, pending_nxt, edge_set, w1c, claim_clr;
  logic [NSRC-1:0] insvc_set, insvc_clr, mode_to_level;
  logic            claim_valid, claim_fire, eoi;
  logic [2:0]      claim_id;
  logic            wdata_unused;

  assign off          = reg_off_e'(addr);
  assign eligible     = pending & enable & ~insvc;
  assign wdata_unused = &{1'b0, wdata[31:NSRC]};

  irq_prio_enc #(.N(NSRC)) u_prio_enc (
    .req   (eligible),
    .valid (claim_valid),
    .id    (claim_id)
  );

  assign claim_fire = re && (off == REG_CLAIM) && claim_valid;
  assign eoi        = we && (off == REG_CLAIM) && ({29'b0, wdata[2:0]} < NSRC);

  always_comb begin
    insvc_set     = '0;
    insvc_clr     = '0;
    claim_clr     = '0;
    w1c           = '0;
    mode_to_level = '0;
    if (claim_fire) begin
      insvc_set[claim_id] = 1'b1;
      claim_clr[claim_id] = 1'b1;
    end
    if (eoi)
      insvc_clr[wdata[2:0]] = 1'b1;
    if (we && off == REG_PENDING)
      w1c = wdata[NSRC-1:0];
    if (we && off == REG_MODE)
      mode_to_level = mode & ~wdata[NSRC-1:0];
    edge_set = dev_irq & ~prev;
    // Set term is OR-ed after the clear so a coincident new edge wins.
    pending_nxt = (mode & (edge_set | (pending & ~(w1c | claim_clr))))
                | (~mode & dev_irq);
    pending_nxt = pending_nxt & ~mode_to_level;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode    <= '0;
      enable  <= '0;
      pending <= '0;
      insvc   <= '0;
      prev    <= '0;
      hw_int  <= '0;
    end else begin
      prev    <= dev_irq;
      pending <= pending_nxt;
      insvc   <= (insvc | insvc_set) & ~insvc_clr;
      hw_int  <= eligible;
      if (we) begin
        case (off)
          REG_MODE:   mode   <= wdata[NSRC-1:0];
          REG_ENABLE: enable <= wdata[NSRC-1:0];
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_MODE:    rdata[NSRC-1:0] = mode;
      REG_ENABLE:  rdata[NSRC-1:0] = enable;
      REG_PENDING: rdata[NSRC-1:0] = pending;
      REG_CLAIM:   rdata           = claim_word(claim_valid, claim_id);
      default:     rdata           = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, edge latency, claim/EOI, level
// sources, set-wins race, empty claim and edge-to-level mode change.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dev_irq;
  logic [1:0]  addr;
  logic        we, re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hw_int;

  int unsigned total = 0;
  int unsigned bad   = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .addr    (addr),
    .we      (we),
    .re      (re),
    .wdata   (wdata),
    .rdata   (rdata),
    .hw_int  (hw_int)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic claim(input logic [31:0] exp, input string tag);
    addr = 2'd3;
    re   = 1'b1;
    #1;
    chk(tag, rdata, exp);
    step();
    re   = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    dev_irq = 6'h3F;
    addr    = 2'd0;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = '0;

    // Reset held with all requests high
    repeat (3) step();
    chk("rst_hw_int", 32'(hw_int), 32'h0);
    rd(2'd0, 32'h0, "rst_mode");
    rd(2'd1, 32'h0, "rst_enable");
    rd(2'd2, 32'h0, "rst_pending");
    rd(2'd3, 32'h0, "rst_claim");
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_hw_int", 32'(hw_int), 32'h0);
    rd(2'd2, 32'h3F, "post_rst_level_pending");
    dev_irq = 6'h00;
    step();
    step();
    rd(2'd2, 32'h0, "level_drop_pending");

    // Edge latency on source 0
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h01);
    dev_irq = 6'h01;
    step();
    dev_irq = 6'h00;
    chk("edge_lat_n1", 32'(hw_int), 32'h00);
    step();
    chk("edge_lat_n2", 32'(hw_int), 32'h01);
    step();
    chk("edge_hold", 32'(hw_int), 32'h01);
    claim(32'h20, "edge_claim0");
    wr(2'd3, 32'h0);
    step();
    chk("edge_after_eoi_hw_int", 32'(hw_int), 32'h00);
    rd(2'd2, 32'h0, "edge_after_claim_pending");

    // Upper bits ignored on write
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h3F, "mode_upper_bits");

    // Claim and EOI with two edge sources
    wr(2'd0, 32'h03);
    wr(2'd1, 32'h03);
    dev_irq = 6'h03;
    step();
    dev_irq = 6'h00;
    step();
    chk("two_hw_int", 32'(hw_int), 32'h03);
    claim(32'h20, "two_claim0");
    step();
    chk("two_hw_int_after_claim", 32'(hw_int), 32'h02);
    claim(32'h21, "two_claim1");
    wr(2'd3, 32'h0);
    wr(2'd3, 32'h1);
    rd(2'd2, 32'h0, "two_pending_cleared");
    chk("two_hw_int_final", 32'(hw_int), 32'h00);

    // Level source 2
    wr(2'd0, 32'h00);
    wr(2'd1, 32'h04);
    dev_irq = 6'h04;
    step();
    step();
    chk("lvl_hw_int", 32'(hw_int), 32'h04);
    claim(32'h22, "lvl_claim");
    step();
    chk("lvl_insvc_masks", 32'(hw_int), 32'h00);
    rd(2'd2, 32'h04, "lvl_pending_kept");
    wr(2'd3, 32'h2);
    chk("lvl_eoi_n1", 32'(hw_int), 32'h00);
    step();
    chk("lvl_reassert", 32'(hw_int), 32'h04);
    dev_irq = 6'h00;
    step();
    chk("lvl_drop_n1", 32'(hw_int), 32'h04);
    step();
    chk("lvl_drop_n2", 32'(hw_int), 32'h00);

    // Set-wins race on edge source 3
    wr(2'd0, 32'h08);
    wr(2'd1, 32'h08);
    dev_irq = 6'h08;
    step();
    dev_irq = 6'h00;
    step();
    rd(2'd2, 32'h08, "race_pending_set");
    dev_irq = 6'h08;
    wr(2'd2, 32'h08);
    rd(2'd2, 32'h08, "race_set_wins");
    step();
    wr(2'd2, 32'h08);
    rd(2'd2, 32'h00, "w1c_clears");
    dev_irq = 6'h00;
    step();

    // Empty claim then edge on source 5
    wr(2'd0, 32'h20);
    wr(2'd1, 32'h20);
    claim(32'h00, "empty_claim");
    dev_irq = 6'h20;
    step();
    dev_irq = 6'h00;
    step();
    chk("empty_then_src5", 32'(hw_int), 32'h20);
    claim(32'h25, "claim_src5");
    wr(2'd3, 32'h5);

    // Edge-to-level mode change drops a latched edge
    dev_irq = 6'h20;
    step();
    dev_irq = 6'h00;
    step();
    rd(2'd2, 32'h20, "src5_pending");
    wr(2'd0, 32'h00);
    rd(2'd2, 32'h00, "mode_change_clears");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
